// File: rtl/mask_stream.sv
// Streaming row/column word mask: one matrix row per beat, masks latched at frame
// start, rows leave through a single registered valid/ready output stage.
//
// state   | meaning
// S_IDLE  | waiting for start; masks/mode may be re-latched
// S_RUN   | accepting rows 0..R-1
// S_DRAIN | last row accepted, waiting for it to leave downstream
module mask_stream #(
  parameter int R       = 3,
  parameter int C       = 4,
  parameter int N       = 16,
  parameter int NORM_NZ = 1,
  localparam int IW     = (R > 1) ? $clog2(R) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [R-1:0]    row_mask,
  input  logic [C-1:0]    col_mask,
  input  logic [1:0]      mode,
  output logic            busy,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [C*N-1:0]  in_row,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [C*N-1:0]  out_row,
  output logic [IW-1:0]   out_idx,
  output logic            out_last,
  output logic            done
);

  localparam logic [IW-1:0] LAST_IDX = IW'(R - 1);
  localparam logic [N-1:0]  NEG_ZERO = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   cnt_q, cnt_d;
  logic [R-1:0]    row_mask_q, row_mask_d;
  logic [C-1:0]    col_mask_q, col_mask_d;
  logic [1:0]      mode_q, mode_d;
  logic            out_valid_q, out_valid_d;
  logic [C*N-1:0]  out_row_q, out_row_d;
  logic [IW-1:0]   out_idx_q, out_idx_d;
  logic            out_last_q, out_last_d;
  logic            done_q, done_d;

  logic            accept;
  logic            out_fire;
  logic            row_keep;
  logic [C-1:0]    word_keep;
  logic [N-1:0]    word;
  logic [C*N-1:0]  masked_row;

  assign in_ready  = (state_q == S_RUN) && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign out_fire  = out_valid_q && out_ready;
  assign busy      = (state_q != S_IDLE);
  assign out_valid = out_valid_q;
  assign out_row   = out_row_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;
  assign done      = done_q;

  always_comb begin
    row_keep = row_mask_q[cnt_q];
    case (mode_q)
      2'd0:    word_keep = {C{row_keep}};
      2'd1:    word_keep = col_mask_q;
      2'd2:    word_keep = col_mask_q & {C{row_keep}};
      default: word_keep = '1;
    endcase
  end

  // Masked words are forced to +0; a kept negative zero is folded to +0 too.
  always_comb begin
    masked_row = '0;
    word       = '0;
    for (int j = 0; j < C; j++) begin
      word = in_row[j*N +: N];
      if (word_keep[j] && !((NORM_NZ != 0) && (word == NEG_ZERO)))
        masked_row[j*N +: N] = word;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    row_mask_d  = row_mask_q;
    col_mask_d  = col_mask_q;
    mode_d      = mode_q;
    out_valid_d = out_valid_q;
    out_row_d   = out_row_q;
    out_idx_d   = out_idx_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_RUN;
          cnt_d      = '0;
          row_mask_d = row_mask;
          col_mask_d = col_mask;
          mode_d     = mode;
        end
      end
      S_RUN: begin
        if (accept && (cnt_q == LAST_IDX))
          state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (out_fire && out_last_q) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A new accept refills the stage in the same cycle the old row leaves.
    if (accept) begin
      out_valid_d = 1'b1;
      out_row_d   = masked_row;
      out_idx_d   = cnt_q;
      out_last_d  = (cnt_q == LAST_IDX);
      cnt_d       = (cnt_q == LAST_IDX) ? '0 : cnt_q + IW'(1);
    end else if (out_fire) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      row_mask_q  <= '0;
      col_mask_q  <= '0;
      mode_q      <= '0;
      out_valid_q <= 1'b0;
      out_row_q   <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      row_mask_q  <= row_mask_d;
      col_mask_q  <= col_mask_d;
      mode_q      <= mode_d;
      out_valid_q <= out_valid_d;
      out_row_q   <= out_row_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
    end
  end

endmodule
